mem_port_arbiter: RTL and testbench

- Sits between the processor core's fetch, memRead and memWrite ports and a single-ported synchronous RAM. It replaces the direct multi-port hookup in the system top.
- Arbitrates the three request streams onto one RAM port, one grant per cycle, using valid/ready handshakes.
- Returns registered responses one cycle after grant.
- Detects misaligned word accesses and returns RISC-V exception codes instead of accessing RAM.

---
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter (fetch/load/store) onto one synchronous single-port RAM.
// Responses appear one cycle after grant. Misaligned word accesses return exceptions and never reach the RAM.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              fetch_req_valid,
  input  logic [ADDR_W-1:0] fetch_req_addr,
  output logic              fetch_req_ready,
  output logic              fetch_rsp_valid,
  output logic [DATA_W-1:0] fetch_rsp_data,
  output logic              fetch_rsp_exc_valid,
  output logic [3:0]        fetch_rsp_exc,
  input  logic              load_req_valid,
  input  logic [ADDR_W-1:0] load_req_addr,
  output logic              load_req_ready,
  output logic              load_rsp_valid,
  output logic [DATA_W-1:0] load_rsp_data,
  output logic              load_rsp_exc_valid,
  output logic [3:0]        load_rsp_exc,
  input  logic              store_req_valid,
  input  logic [ADDR_W-1:0] store_req_addr,
  input  logic [DATA_W-1:0] store_req_data,
  output logic              store_req_ready,
  output logic              store_rsp_valid,
  output logic              store_rsp_exc_valid,
  output logic [3:0]        store_rsp_exc,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {SRC_NONE, SRC_FETCH, SRC_LOAD, SRC_STORE} src_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  src_e              gnt_src;
  logic [ADDR_W-1:0] gnt_addr;
  logic              gnt_mis;
  logic              ram_go;
  src_e              src_q;
  logic              mis_q;
  logic [3:0]        starve_q, starve_d;

  // A fetch starved for LIMIT cycles jumps ahead of store and load.
  always_comb begin
    gnt_src = SRC_NONE;
    if (!RESET) begin
      if (fetch_req_valid && (starve_q >= LIMIT)) gnt_src = SRC_FETCH;
      else if (store_req_valid)                   gnt_src = SRC_STORE;
      else if (load_req_valid)                    gnt_src = SRC_LOAD;
      else if (fetch_req_valid)                   gnt_src = SRC_FETCH;
    end
  end

  always_comb begin
    gnt_addr = '0;
    case (gnt_src)
      SRC_FETCH: gnt_addr = fetch_req_addr;
      SRC_LOAD:  gnt_addr = load_req_addr;
      SRC_STORE: gnt_addr = store_req_addr;
      default:   gnt_addr = '0;
    endcase
  end

  assign gnt_mis = (gnt_addr[1:0] != 2'b00);
  assign ram_go  = (gnt_src != SRC_NONE) && !gnt_mis;

  assign fetch_req_ready = (gnt_src == SRC_FETCH);
  assign load_req_ready  = (gnt_src == SRC_LOAD);
  assign store_req_ready = (gnt_src == SRC_STORE);

  assign ram_en    = ram_go;
  assign ram_we    = ram_go && (gnt_src == SRC_STORE);
  assign ram_addr  = ram_go ? gnt_addr[ADDR_W-1:2] : '0;
  assign ram_wdata = (ram_go && (gnt_src == SRC_STORE)) ? store_req_data : '0;

  always_comb begin
    starve_d = starve_q;
    if (gnt_src == SRC_FETCH)                       starve_d = 4'd0;
    else if (fetch_req_valid && (starve_q < LIMIT)) starve_d = starve_q + 4'd1;
  end

  // Clearing src_q on reset drops any response still in flight.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      src_q    <= SRC_NONE;
      mis_q    <= 1'b0;
      starve_q <= 4'd0;
    end else begin
      src_q    <= gnt_src;
      mis_q    <= gnt_mis;
      starve_q <= starve_d;
    end
  end

  // RAM read data arrives the cycle after ram_en, so it passes straight through to the granted port.
  assign fetch_rsp_valid     = (src_q == SRC_FETCH);
  assign fetch_rsp_exc_valid = fetch_rsp_valid && mis_q;
  assign fetch_rsp_exc       = 4'd0;
  assign fetch_rsp_data      = (fetch_rsp_valid && !mis_q) ? ram_rdata : '0;

  assign load_rsp_valid      = (src_q == SRC_LOAD);
  assign load_rsp_exc_valid  = load_rsp_valid && mis_q;
  assign load_rsp_exc        = load_rsp_exc_valid ? 4'd4 : 4'd0;
  assign load_rsp_data       = (load_rsp_valid && !mis_q) ? ram_rdata : '0;

  assign store_rsp_valid     = (src_q == SRC_STORE);
  assign store_rsp_exc_valid = store_rsp_valid && mis_q;
  assign store_rsp_exc       = store_rsp_exc_valid ? 4'd6 : 4'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter: a reference model predicts grants and responses;
// a separate monitor pops expected responses from per-port queues and checks them.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, LIM = 4;
  localparam int G_NONE = 0, G_F = 1, G_L = 2, G_S = 3;

  logic CLK = 1'b0, RESET;
  logic fv, lv, sv;
  logic [AW-1:0] fa, la, sa;
  logic [DW-1:0] sd;
  logic fetch_req_ready, fetch_rsp_valid, fetch_rsp_exc_valid;
  logic [DW-1:0] fetch_rsp_data;
  logic [3:0] fetch_rsp_exc;
  logic load_req_ready, load_rsp_valid, load_rsp_exc_valid;
  logic [DW-1:0] load_rsp_data;
  logic [3:0] load_rsp_exc;
  logic store_req_ready, store_rsp_valid, store_rsp_exc_valid;
  logic [3:0] store_rsp_exc;
  logic ram_en, ram_we;
  logic [AW-3:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .CLK(CLK), .RESET(RESET),
    .fetch_req_valid(fv), .fetch_req_addr(fa), .fetch_req_ready(fetch_req_ready),
    .fetch_rsp_valid(fetch_rsp_valid), .fetch_rsp_data(fetch_rsp_data),
    .fetch_rsp_exc_valid(fetch_rsp_exc_valid), .fetch_rsp_exc(fetch_rsp_exc),
    .load_req_valid(lv), .load_req_addr(la), .load_req_ready(load_req_ready),
    .load_rsp_valid(load_rsp_valid), .load_rsp_data(load_rsp_data),
    .load_rsp_exc_valid(load_rsp_exc_valid), .load_rsp_exc(load_rsp_exc),
    .store_req_valid(sv), .store_req_addr(sa), .store_req_data(sd), .store_req_ready(store_req_ready),
    .store_rsp_valid(store_rsp_valid), .store_rsp_exc_valid(store_rsp_exc_valid), .store_rsp_exc(store_rsp_exc),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          stamp;
    logic [31:0] data;
    logic        ev;
    logic [3:0]  exc;
  } rsp_t;

  rsp_t        expq [3][$];
  logic [31:0] mdl [0:255];
  logic [31:0] ram [0:255];
  logic        ld_en;
  int          cyc = 0;
  int          starve;
  int          checks = 0, errors = 0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'h13;
    if (i == 1) return 32'h93;
    if (i == 2) return 32'h113;
    return (i * 32'h01010101) ^ 32'h5a5a0000;
  endfunction

  // Synchronous single-port RAM model
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (ld_en) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else if (ram_en) begin
      if (ram_we) ram[ram_addr[7:0]] <= ram_wdata;
      ram_rdata <= ram[ram_addr[7:0]];
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic mon(input int s, input logic v, input logic [31:0] d, input logic ev, input logic [3:0] ex);
    rsp_t e;
    if (v) begin
      if (expq[s].size() == 0) begin
        chk($sformatf("unexpected_rsp_port%0d", s), 32'd1, 32'd0);
      end else begin
        e = expq[s].pop_front();
        chk($sformatf("rsp_cycle_port%0d", s), cyc, e.stamp);
        chk($sformatf("rsp_data_port%0d", s), d, e.data);
        chk($sformatf("rsp_excv_port%0d", s), {31'd0, ev}, {31'd0, e.ev});
        chk($sformatf("rsp_exc_port%0d", s), {28'd0, ex}, {28'd0, e.exc});
      end
    end else if (expq[s].size() > 0 && expq[s][0].stamp <= cyc) begin
      e = expq[s].pop_front();
      chk($sformatf("missing_rsp_port%0d", s), 32'd0, 32'd1);
    end
  endtask

  always @(negedge CLK) begin
    if (!RESET) begin
      mon(0, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_exc_valid, fetch_rsp_exc);
      mon(1, load_rsp_valid, load_rsp_data, load_rsp_exc_valid, load_rsp_exc);
      mon(2, store_rsp_valid, 32'd0, store_rsp_exc_valid, store_rsp_exc);
    end
  end

  // Reference model: predicts the winner from the priority rules, checks the grant-cycle
  // outputs and queues the expected response for the next cycle.
  task automatic tick(output int g);
    rsp_t r;
    logic [31:0] a;
    logic mis, en;
    @(negedge CLK);
    g = G_NONE;
    if (fv && starve >= LIM) g = G_F;
    else if (sv)             g = G_S;
    else if (lv)             g = G_L;
    else if (fv)             g = G_F;
    chk("fetch_ready", {31'd0, fetch_req_ready}, {31'd0, g == G_F});
    chk("load_ready",  {31'd0, load_req_ready},  {31'd0, g == G_L});
    chk("store_ready", {31'd0, store_req_ready}, {31'd0, g == G_S});
    a   = (g == G_F) ? fa : (g == G_L) ? la : (g == G_S) ? sa : 32'd0;
    mis = (a % 4) != 0;
    en  = (g != G_NONE) && !mis;
    chk("ram_en",    {31'd0, ram_en}, {31'd0, en});
    chk("ram_we",    {31'd0, ram_we}, {31'd0, en && g == G_S});
    chk("ram_addr",  {2'b00, ram_addr}, en ? a / 4 : 32'd0);
    chk("ram_wdata", ram_wdata, (en && g == G_S) ? sd : 32'd0);
    if (g != G_NONE) begin
      r.stamp = cyc + 1;
      r.ev    = mis;
      r.exc   = !mis ? 4'd0 : (g == G_L) ? 4'd4 : (g == G_S) ? 4'd6 : 4'd0;
      r.data  = (mis || g == G_S) ? 32'd0 : mdl[(a / 4) % 256];
      expq[g-1].push_back(r);
      if (g == G_S && !mis) mdl[(a / 4) % 256] = sd;
    end
    if (g == G_F)                 starve = 0;
    else if (fv && starve < LIM)  starve++;
    @(posedge CLK); #1;
  endtask

  task automatic chk_quiet(input string n);
    chk({n, "_rdy"}, {29'd0, fetch_req_ready, load_req_ready, store_req_ready}, 32'd0);
    chk({n, "_ram_en"}, {31'd0, ram_en}, 32'd0);
    chk({n, "_rspv"}, {29'd0, fetch_rsp_valid, load_rsp_valid, store_rsp_valid}, 32'd0);
    chk({n, "_excv"}, {29'd0, fetch_rsp_exc_valid, load_rsp_exc_valid, store_rsp_exc_valid}, 32'd0);
    chk({n, "_exc"}, {20'd0, fetch_rsp_exc, load_rsp_exc, store_rsp_exc}, 32'd0);
    chk({n, "_fdata"}, fetch_rsp_data, 32'd0);
    chk({n, "_ldata"}, load_rsp_data, 32'd0);
  endtask

  function automatic logic [31:0] raddr();
    logic [7:0] idx;
    logic [1:0] lo;
    idx = 8'($urandom_range(0, 255));
    lo  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
    return {22'd0, idx, lo};
  endfunction

  initial begin
    int g;
    RESET = 1'b1; ld_en = 1'b1; starve = 0;
    for (int i = 0; i < 256; i++) mdl[i] = init_word(i);
    fv = 1'b1; fa = 32'h0; lv = 1'b1; la = 32'h100; sv = 1'b1; sa = 32'h200; sd = 32'h1;
    @(posedge CLK); #1;
    ld_en = 1'b0;
    @(negedge CLK);
    chk_quiet("reset");
    fv = 1'b0; lv = 1'b0; sv = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;

    // Idle
    for (int c = 0; c < 3; c++) tick(g);

    // Back-to-back fetches of preloaded words
    fv = 1'b1; fa = 32'h0; tick(g);
    fa = 32'h4; tick(g);
    fa = 32'h8; tick(g);
    fv = 1'b0; tick(g);

    // Same-cycle store/load conflict on one address
    sv = 1'b1; sa = 32'h200; sd = 32'hDEADBEEF; lv = 1'b1; la = 32'h200;
    chk("conflict_store_rdy", {31'd0, store_req_ready}, 32'd1);
    chk("conflict_load_rdy", {31'd0, load_req_ready}, 32'd0);
    tick(g);
    sv = 1'b0;
    chk("conflict_load_rdy2", {31'd0, load_req_ready}, 32'd1);
    tick(g);
    lv = 1'b0; tick(g);

    // Starvation: four loads, then the fetch, then loads again
    lv = 1'b1; la = 32'h100; fv = 1'b1; fa = 32'h0;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("starve_fetch_rdy_c%0d", c), {31'd0, fetch_req_ready}, {31'd0, c == 4});
      chk($sformatf("starve_load_rdy_c%0d", c), {31'd0, load_req_ready}, {31'd0, c != 4});
      tick(g);
    end
    lv = 1'b0; fv = 1'b0; tick(g);

    // Misaligned accesses of each kind
    fv = 1'b1; fa = 32'h2; tick(g);
    fv = 1'b0; lv = 1'b1; la = 32'h105; tick(g);
    lv = 1'b0; sv = 1'b1; sa = 32'h203; sd = 32'hFFFFFFFF; tick(g);
    sv = 1'b0; tick(g); tick(g);
    chk("misaligned_store_ram_word", ram[8'h80], 32'hDEADBEEF);

    // Reset asserted the cycle after a load grant
    lv = 1'b1; la = 32'h100; tick(g);
    RESET = 1'b1; lv = 1'b0;
    for (int s = 0; s < 3; s++) expq[s].delete();
    starve = 0;
    #1;
    chk_quiet("midreset");
    @(negedge CLK);
    chk_quiet("midreset_neg");
    @(posedge CLK); #1;
    RESET = 1'b0;
    lv = 1'b1; la = 32'h100; tick(g);
    lv = 1'b0; tick(g);

    // Random traffic with held requests until granted
    for (int i = 0; i < 400; i++) begin
      if (!fv && $urandom_range(0, 1) == 1) begin fv = 1'b1; fa = raddr(); end
      if (!lv && $urandom_range(0, 2) == 0) begin lv = 1'b1; la = raddr(); end
      if (!sv && $urandom_range(0, 2) == 0) begin sv = 1'b1; sa = raddr(); sd = $urandom; end
      tick(g);
      if (g == G_F) fv = 1'b0;
      if (g == G_L) lv = 1'b0;
      if (g == G_S) sv = 1'b0;
    end
    fv = 1'b0; lv = 1'b0; sv = 1'b0;
    for (int c = 0; c < 3; c++) tick(g);
    chk("drain_fetch_q", expq[0].size(), 32'd0);
    chk("drain_load_q",  expq[1].size(), 32'd0);
    chk("drain_store_q", expq[2].size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
